// File: rtl/rf_wb_arbiter_pkg.sv
// rf_wb_arbiter_pkg: shared constants and types for the writeback arbiter
package rf_wb_arbiter_pkg;
  localparam int unsigned NREQ = 3;
  localparam int unsigned ADDR_W = 5;
  localparam int unsigned DATA_W = 32;
  localparam int unsigned STARVE_LIMIT = 4;
  localparam int unsigned CNT_W = $clog2(STARVE_LIMIT + 1);
  localparam int unsigned NREG = 2 ** ADDR_W;
  localparam int unsigned REQ_ALU = 0;
  localparam int unsigned REQ_LOAD = 1;
  localparam int unsigned REQ_MULDIV = 2;
  typedef logic [CNT_W-1:0] cnt_t;
endpackage

// File: rtl/rf_wb_arbiter_if.sv
// rf_wb_arbiter_if: writeback request, reservation and register-file write bundle
interface rf_wb_arbiter_if;
  import rf_wb_arbiter_pkg::*;
  logic [NREQ-1:0] req_valid;
  logic [NREQ*ADDR_W-1:0] req_addr;
  logic [NREQ*DATA_W-1:0] req_data;
  logic [NREQ-1:0] req_ready;
  logic rsv_valid;
  logic [ADDR_W-1:0] rsv_addr;
  logic rf_we;
  logic [ADDR_W-1:0] rf_waddr;
  logic [DATA_W-1:0] rf_wdata;
  logic [NREG-1:0] busy;
  modport master(output req_valid, req_addr, req_data, rsv_valid, rsv_addr,
                 input req_ready, rf_we, rf_waddr, rf_wdata, busy);
  modport slave(input req_valid, req_addr, req_data, rsv_valid, rsv_addr,
                output req_ready, rf_we, rf_waddr, rf_wdata, busy);
endinterface

// File: rtl/rf_wb_prio_pick.sv
// rf_wb_prio_pick: one-hot grant to the lowest-index starved requester, else lowest-index valid
module rf_wb_prio_pick
  import rf_wb_arbiter_pkg::*;
(
  input  logic [NREQ-1:0] valid,
  input  logic [NREQ-1:0] starved,
  output logic [NREQ-1:0] grant
);
  logic [NREQ-1:0] cand;
  assign cand = |(valid & starved) ? (valid & starved) : valid;
  assign grant = cand & (~cand + NREQ'(1));
endmodule

// File: rtl/rf_wb_arbiter.sv
// rf_wb_arbiter: shares the register-file write port among writeback sources and tracks pending writes
module rf_wb_arbiter
  import rf_wb_arbiter_pkg::*;
(
  input logic clk,
  input logic rst_n,
  rf_wb_arbiter_if.slave bus
);
  cnt_t cnt [NREQ];
  logic [NREQ-1:0] starved, grant;
  logic [ADDR_W-1:0] sel_a;
  logic [DATA_W-1:0] sel_d;
  logic xfer, wr;
  logic [NREG-1:0] clr, set;
  // flag requesters that have lost enough consecutive cycles to be promoted
  always_comb
    for (int i = 0; i < NREQ; i++) starved[i] = cnt[i] >= cnt_t'(STARVE_LIMIT);
  rf_wb_prio_pick u_pick (.valid(bus.req_valid), .starved(starved), .grant(grant));
  assign bus.req_ready = rst_n ? grant : '0;
  assign xfer = |bus.req_ready;
  // route the granted requester's address and data
  always_comb begin
    sel_a = '0;
    sel_d = '0;
    for (int i = 0; i < NREQ; i++)
      if (grant[i]) begin
        sel_a = bus.req_addr[i*ADDR_W +: ADDR_W];
        sel_d = bus.req_data[i*DATA_W +: DATA_W];
      end
  end
  assign wr = xfer && sel_a != '0;
  assign clr = xfer ? NREG'(1) << sel_a : '0;
  assign set = (bus.rsv_valid && bus.rsv_addr != '0) ? NREG'(1) << bus.rsv_addr : '0;
  // losing requesters count up to the limit, winners and idle ones restart
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n)
      for (int i = 0; i < NREQ; i++) cnt[i] <= '0;
    else
      for (int i = 0; i < NREQ; i++)
        cnt[i] <= (bus.req_valid[i] && !grant[i]) ? (starved[i] ? cnt[i] : cnt[i] + cnt_t'(1)) : '0;
  // register the granted write; writes to r0 are swallowed
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      bus.rf_we <= 1'b0;
      bus.rf_waddr <= '0;
      bus.rf_wdata <= '0;
    end else begin
      bus.rf_we <= wr;
      if (wr) begin
        bus.rf_waddr <= sel_a;
        bus.rf_wdata <= sel_d;
      end
    end
  // commit clears first so a same-cycle reservation of the same register wins
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) bus.busy <= '0;
    else bus.busy <= (bus.busy & ~clr) | set;
endmodule
